// File: rtl/instruction_issuer_pkg.sv
// Shared definitions for the GPU instruction producer: word width, opcode range, FSM states.
// No logic of its own; the legality check is a pure function.
// Consumers of the instruction port import the same opcode values.
package instruction_issuer_pkg;

  localparam int INSTR_W = 32;

  localparam logic [7:0] OP_SET_BG_COLOR = 8'h01;
  localparam logic [7:0] OP_SET_PIXEL    = 8'h07;
  localparam logic [7:0] OPCODE_MIN      = OP_SET_BG_COLOR;
  localparam logic [7:0] OPCODE_MAX      = OP_SET_PIXEL;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_GAP   = 2'd2
  } issue_state_e;

  function automatic logic opcode_legal(input logic [7:0] op);
    return (op >= OPCODE_MIN) && (op <= OPCODE_MAX);
  endfunction

endpackage

// File: rtl/instruction_issuer_fifo.sv
// Synchronous word FIFO with occupancy count; head word is visible combinationally.
// Latency: a pushed word is readable the cycle after the push edge.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module instruction_issuer_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_pop_data,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok, pop_ok;

  // Accept/advance decisions; pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    pop_ok  = i_pop && (cnt_q != '0);
    push_ok = i_push && ((cnt_q != CW'(DEPTH)) || pop_ok);
    wr_d    = wr_q + AW'(push_ok);
    rd_d    = rd_q + AW'(pop_ok);
    cnt_d   = cnt_q + CW'(push_ok) - CW'(pop_ok);
  end

  // Pointer and occupancy state.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage; contents are meaningless once the count is cleared, so no reset here.
  always_ff @(posedge i_clk) begin
    if (push_ok) mem_q[wr_q] <= i_push_data;
  end

  assign o_pop_data = mem_q[rd_q];
  assign o_count    = cnt_q;

endmodule

// File: rtl/instruction_issuer.sv
// Packs UART bytes into 32-bit instructions, drops illegal opcodes, queues and issues them as pulses.
// Latency: 4th byte sampled at edge k -> o_instruction_ready high from edge k+1 to k+2.
// No backpressure on the byte stream: a legal word arriving at a full FIFO is dropped and flagged.
module instruction_issuer
  import instruction_issuer_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ISSUE_GAP  = 2,
  parameter int TIMEOUT    = 50000
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [7:0]         i_rx_byte,
  input  logic               i_rx_valid,
  output logic [INSTR_W-1:0] o_instruction,
  output logic               o_instruction_ready,
  output logic               o_fifo_full,
  output logic               o_overflow,
  output logic               o_frame_error,
  output logic [7:0]         o_drop_count
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic [1:0]         b_q, b_d;
  logic [23:0]        lanes_q, lanes_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               frame_err_q, frame_err_d;
  logic               word_vld;
  logic [INSTR_W-1:0] word_dat;

  logic               word_legal, push, pop, fifo_full, fifo_empty;
  logic [INSTR_W-1:0] fifo_head;
  logic [CW-1:0]      fifo_count;
  logic               overflow_q, overflow_d;
  logic [7:0]         drop_q, drop_d;

  issue_state_e       state_q, state_d;
  logic [3:0]         gap_q, gap_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               rdy_q, rdy_d;

  // Byte assembler: lanes fill little-endian; the 4th byte completes the word in the same cycle.
  always_comb begin
    b_d         = b_q;
    lanes_d     = lanes_q;
    tmo_d       = tmo_q;
    frame_err_d = 1'b0;
    word_vld    = 1'b0;
    word_dat    = {i_rx_byte, lanes_q};
    if (i_rx_valid) begin
      // A byte always beats a timeout that would fire in the same cycle.
      tmo_d = '0;
      if (b_q == 2'd3) begin
        word_vld = 1'b1;
        b_d      = 2'd0;
      end else begin
        b_d = b_q + 2'd1;
        case (b_q)
          2'd0:    lanes_d[7:0]   = i_rx_byte;
          2'd1:    lanes_d[15:8]  = i_rx_byte;
          default: lanes_d[23:16] = i_rx_byte;
        endcase
      end
    end else if (b_q != 2'd0) begin
      if (tmo_q == TMO_LAST) begin
        b_d         = 2'd0;
        tmo_d       = '0;
        frame_err_d = 1'b1;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end
  end

  // Validation and drop accounting; an illegal opcode is never also counted as an overflow.
  always_comb begin
    word_legal = opcode_legal(word_dat[7:0]);
    push       = word_vld && word_legal;
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (push && fifo_full && !pop) overflow_d = 1'b1;
    if (word_vld && (!word_legal || (fifo_full && !pop)) && (drop_q != 8'hFF))
      drop_d = drop_q + 8'd1;
  end

  // Issue FSM. The last GAP cycle doubles as the IDLE decision cycle so that exactly
  // ISSUE_GAP low cycles separate queued pulses; with ISSUE_GAP=0 the IDLE cycle still
  // keeps one low cycle between pulses so the consumer never sees them merged.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    pop     = 1'b0;
    instr_d = '0;
    rdy_d   = 1'b0;
    case (state_q)
      ST_ISSUE: begin
        if (ISSUE_GAP == 0) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_GAP;
          gap_d   = 4'(ISSUE_GAP);
        end
      end
      ST_GAP: begin
        gap_d = gap_q - 4'd1;
        if (gap_q <= 4'd1) begin
          gap_d   = 4'd0;
          state_d = ST_IDLE;
          pop     = !fifo_empty;
        end
      end
      default: begin
        pop = !fifo_empty && (gap_q == 4'd0);
      end
    endcase
    if (pop) begin
      state_d = ST_ISSUE;
      instr_d = fifo_head;
      rdy_d   = 1'b1;
    end
  end

  // All control and output registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      b_q         <= 2'd0;
      lanes_q     <= '0;
      tmo_q       <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      drop_q      <= 8'd0;
      state_q     <= ST_IDLE;
      gap_q       <= 4'd0;
      instr_q     <= '0;
      rdy_q       <= 1'b0;
    end else begin
      b_q         <= b_d;
      lanes_q     <= lanes_d;
      tmo_q       <= tmo_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
      drop_q      <= drop_d;
      state_q     <= state_d;
      gap_q       <= gap_d;
      instr_q     <= instr_d;
      rdy_q       <= rdy_d;
    end
  end

  instruction_issuer_fifo #(
    .WIDTH (INSTR_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_push      (push),
    .i_push_data (word_dat),
    .i_pop       (pop),
    .o_pop_data  (fifo_head),
    .o_count     (fifo_count)
  );

  assign fifo_full  = (fifo_count == CW'(FIFO_DEPTH));
  assign fifo_empty = (fifo_count == '0);

  assign o_instruction       = instr_q;
  assign o_instruction_ready = rdy_q;
  assign o_fifo_full         = fifo_full;
  assign o_overflow          = overflow_q;
  assign o_frame_error       = frame_err_q;
  assign o_drop_count        = drop_q;

endmodule

// File: tb/tb_instruction_issuer.sv
// Directed bench: two issuers share one byte stream; u_fast (gap 2) and u_slow (gap 15).
// Both use TIMEOUT=16 so frame errors are reachable in a short run.
// Pulses and frame errors are logged at negedge with a cycle stamp and checked per test.
module tb_instruction_issuer;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic [7:0]  i_rx_byte = 8'h00;
  logic        i_rx_valid = 1'b0;

  logic [31:0] f_instr, s_instr;
  logic        f_rdy, s_rdy, f_full, s_full, f_ovf, s_ovf, f_fe, s_fe;
  logic [7:0]  f_drop, s_drop;

  instruction_issuer #(.FIFO_DEPTH(8), .ISSUE_GAP(2), .TIMEOUT(16)) u_fast (
    .i_clk(i_clk), .i_reset(i_reset), .i_rx_byte(i_rx_byte), .i_rx_valid(i_rx_valid),
    .o_instruction(f_instr), .o_instruction_ready(f_rdy), .o_fifo_full(f_full),
    .o_overflow(f_ovf), .o_frame_error(f_fe), .o_drop_count(f_drop));

  instruction_issuer #(.FIFO_DEPTH(8), .ISSUE_GAP(15), .TIMEOUT(16)) u_slow (
    .i_clk(i_clk), .i_reset(i_reset), .i_rx_byte(i_rx_byte), .i_rx_valid(i_rx_valid),
    .o_instruction(s_instr), .o_instruction_ready(s_rdy), .o_fifo_full(s_full),
    .o_overflow(s_ovf), .o_frame_error(s_fe), .o_drop_count(s_drop));

  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  logic [31:0] f_q[$], s_q[$];
  int          f_t[$], s_t[$];
  int          viol = 0;
  int          fe_cnt = 0;
  int          fe_t = 0;

  always @(negedge i_clk) begin
    if (f_rdy) begin f_q.push_back(f_instr); f_t.push_back(cyc); end
    else if (f_instr != 32'h0) viol = viol + 1;
    if (s_rdy) begin s_q.push_back(s_instr); s_t.push_back(cyc); end
    else if (s_instr != 32'h0) viol = viol + 1;
    if (f_fe) begin fe_cnt = fe_cnt + 1; fe_t = cyc; end
  end

  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec = n_vec + 1;
    if (got !== exp) begin
      n_miss = n_miss + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] fval(input int i);
    return (i < f_q.size()) ? f_q[i] : 32'hxxxxxxxx;
  endfunction
  function automatic logic [31:0] sval(input int i);
    return (i < s_q.size()) ? s_q[i] : 32'hxxxxxxxx;
  endfunction
  function automatic int ftime(input int i);
    return (i < f_t.size()) ? f_t[i] : -1;
  endfunction
  function automatic int stime(input int i);
    return (i < s_t.size()) ? s_t[i] : -1;
  endfunction

  // Word n of the overflow/reset sequences: legal opcode cycling 1..7, distinct args.
  function automatic logic [31:0] mk(input int n);
    logic [7:0] op;
    op = 8'(((n - 1) % 7) + 1);
    return {8'(n), 8'h5A, 8'(n * 3), op};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_byte  = b;
    i_rx_valid = 1'b1;
    @(posedge i_clk);
    #1;
    i_rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    idle(2);
    i_reset = 1'b0;
    idle(1);
  endtask

  int fb, sb, feb, k, e;

  initial begin
    // Reset state
    idle(2);
    chk("rst_fast", {f_instr, f_rdy, f_full, f_ovf, f_fe, f_drop}, 64'h0);
    chk("rst_slow", {s_instr, s_rdy, s_full, s_ovf, s_fe, s_drop}, 64'h0);
    i_reset = 1'b0;
    idle(2);

    // 1: single word, exact latency and one-cycle pulse
    fb = f_q.size();
    send_word(32'h000F0001);
    k = cyc;
    idle(6);
    chk("t1_count", f_q.size() - fb, 1);
    chk("t1_word", fval(fb), 32'h000F0001);
    chk("t1_time", ftime(fb), k + 1);

    // 2: three words back-to-back; byte rate limits the pulse period to 4 cycles
    fb = f_q.size();
    send_word(32'h00000002);
    send_word(32'h11111103);
    send_word(32'h22222204);
    idle(8);
    chk("t2_count", f_q.size() - fb, 3);
    chk("t2_w0", fval(fb),     32'h00000002);
    chk("t2_w1", fval(fb + 1), 32'h11111103);
    chk("t2_w2", fval(fb + 2), 32'h22222204);
    chk("t2_space01", ftime(fb + 1) - ftime(fb), 4);
    chk("t2_space12", ftime(fb + 2) - ftime(fb + 1), 4);

    // 3: illegal opcode dropped and counted, legal word behind it issued
    do_reset();
    fb = f_q.size();
    send_word(32'h44332209);
    send_word(32'h00000105);
    idle(6);
    chk("t3_count", f_q.size() - fb, 1);
    chk("t3_word", fval(fb), 32'h00000105);
    chk("t3_drop", f_drop, 8'd1);
    chk("t3_ovf", f_ovf, 1'b0);

    // 4a: partial word times out after 16 idle cycles
    do_reset();
    fb  = f_q.size();
    feb = fe_cnt;
    send_byte(8'hA1);
    send_byte(8'hA2);
    e = cyc;
    idle(20);
    chk("t4_fe_count", fe_cnt - feb, 1);
    chk("t4_fe_time", fe_t, e + 16);
    chk("t4_no_issue", f_q.size() - fb, 0);
    send_word(32'h33221107);
    idle(6);
    chk("t4_word", fval(fb), 32'h33221107);

    // 4b: byte arriving in the cycle the timeout would fire wins
    fb  = f_q.size();
    feb = fe_cnt;
    send_byte(8'h03);
    idle(15);
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    idle(6);
    chk("t4b_fe_none", fe_cnt - feb, 0);
    chk("t4b_count", f_q.size() - fb, 1);
    chk("t4b_word", fval(fb), 32'hCCBBAA03);

    // 5: gap 15, 12 words at full byte rate. Word n is pushed at edge k+4(n-1);
    // pops at k+1, k+17, k+33, k+49. Occupancy after word 11 = 11-3 = 8, so word 12
    // (edge k+44) meets a full FIFO with no pop and is dropped.
    do_reset();
    sb = s_q.size();
    for (int n = 1; n <= 12; n++) send_word(mk(n));
    chk("t5_full", s_full, 1'b1);
    chk("t5_ovf", s_ovf, 1'b1);
    chk("t5_drop", s_drop, 8'd1);
    idle(200);
    chk("t5_count", s_q.size() - sb, 11);
    for (int n = 1; n <= 11; n++) chk($sformatf("t5_w%0d", n), sval(sb + n - 1), mk(n));
    for (int n = 1; n <= 10; n++)
      chk($sformatf("t5_space%0d", n), stime(sb + n) - stime(sb + n - 1), 16);
    chk("t5_drained", s_full, 1'b0);
    chk("t5_ovf_sticky", s_ovf, 1'b1);

    // 6: reset with 3 queued words, 2 bytes assembled and a nonzero drop count
    do_reset();
    send_word(32'h000000FF);
    for (int n = 1; n <= 4; n++) send_word(mk(n));
    send_byte(8'h01);
    send_byte(8'h02);
    chk("t6_pre_drop", s_drop, 8'd1);
    @(negedge i_clk);
    i_reset = 1'b1;
    #1;
    chk("t6_rst_slow", {s_instr, s_rdy, s_full, s_ovf, s_fe, s_drop}, 64'h0);
    chk("t6_rst_fast", {f_instr, f_rdy, f_full, f_ovf, f_fe, f_drop}, 64'h0);
    idle(2);
    i_reset = 1'b0;
    sb = s_q.size();
    idle(40);
    chk("t6_quiet", s_q.size() - sb, 0);
    send_word(32'h00ABCD06);
    idle(6);
    chk("t6_count", s_q.size() - sb, 1);
    chk("t6_word", sval(sb), 32'h00ABCD06);

    chk("idle_instr_zero", viol, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
